// File: rtl/fp_pkg.sv
// Shared definitions for the float ALU result path: flag layout, canonical
// NaN and the packed result+flags word stored in the collector FIFO.
package fp_pkg;

  localparam int FLAG_W      = 5;
  localparam int F_OVERFLOW  = 0;
  localparam int F_UNDERFLOW = 1;
  localparam int F_INEXACT   = 2;
  localparam int F_INVALID   = 3;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  typedef struct packed {
    logic [31:0]       result;
    logic [FLAG_W-1:0] flags;
  } fp_res_t;

endpackage : fp_pkg

// File: rtl/fp_sync_fifo.sv
// Single-clock FIFO with extra pointer MSB for full/empty; the head word is
// visible combinationally and reads as zero while empty.
module fp_sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = CW - 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + CW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule : fp_sync_fifo

// File: rtl/fp_result_collector.sv
// Buffers float ALU results behind a valid/ready port, gates ALU starts with
// credits so no result is ever produced without space, and keeps sticky flags.
module fp_result_collector
  import fp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_req,
  output logic              issue_grant,
  input  logic              alu_valid,
  input  logic [31:0]       alu_result,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [FLAG_W-1:0] out_flags,
  output logic [FLAG_W-1:0] sticky_flags,
  input  logic              sticky_clr,
  output logic [CW-1:0]     in_flight,
  output logic [CW-1:0]     count,
  output logic              overflow_err
);

  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [CW-1:0]     in_flight_q, in_flight_d;
  logic [FLAG_W-1:0] sticky_q, sticky_d;
  logic              err_q, err_d;
  logic [CW:0]       occupancy;
  logic              pending, accept, pop;
  logic              fifo_full, fifo_empty;
  fp_res_t           wr_word, head_word;

  // Grant looks only at registered state so the ALU's same-cycle special-case
  // result cannot form a loop back into start.
  assign occupancy   = {1'b0, in_flight_q} + {1'b0, count};
  assign issue_grant = issue_req && (occupancy < DEPTH_W);
  assign pending     = (in_flight_q != '0) || issue_grant;
  assign out_valid   = !fifo_empty;
  assign pop         = out_valid && out_ready;
  assign accept      = alu_valid && pending && (!fifo_full || pop);

  assign wr_word.result = alu_result;
  assign wr_word.flags  = alu_flags;
  assign out_result     = head_word.result;
  assign out_flags      = head_word.flags;
  assign in_flight      = in_flight_q;
  assign sticky_flags   = sticky_q;
  assign overflow_err   = err_q;

  fp_sync_fifo #(
    .WIDTH ($bits(fp_res_t)),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .wdata (wr_word),
    .pop   (pop),
    .rdata (head_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  always_comb begin
    in_flight_d = in_flight_q + CW'(issue_grant) - CW'(accept);
    sticky_d    = sticky_clr ? '0 : sticky_q;
    err_d       = err_q;
    // Flags of a capture in the clear cycle land after the clear.
    if (accept) sticky_d = sticky_d | alu_flags;
    if (alu_valid && !accept) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight_q <= '0;
      sticky_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      in_flight_q <= in_flight_d;
      sticky_q    <= sticky_d;
      err_q       <= err_d;
    end
  end

endmodule : fp_result_collector

// File: tb/tb_fp_result_collector.sv
// Directed bench for fp_result_collector: credits, capture, sticky flags,
// protocol error and asynchronous reset, with a per-cycle credit invariant.
module tb_fp_result_collector;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          issue_req = 1'b0;
  logic          issue_grant;
  logic          alu_valid = 1'b0;
  logic [31:0]   alu_result = '0;
  logic [4:0]    alu_flags = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_result;
  logic [4:0]    out_flags;
  logic [4:0]    sticky_flags;
  logic          sticky_clr = 1'b0;
  logic [CW-1:0] in_flight;
  logic [CW-1:0] count;
  logic          overflow_err;

  int checks   = 0;
  int failures = 0;

  fp_result_collector #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_req    (issue_req),
    .issue_grant  (issue_grant),
    .alu_valid    (alu_valid),
    .alu_result   (alu_result),
    .alu_flags    (alu_flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .sticky_flags (sticky_flags),
    .sticky_clr   (sticky_clr),
    .in_flight    (in_flight),
    .count        (count),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    issue_req  = 1'b0;
    alu_valid  = 1'b0;
    alu_result = '0;
    alu_flags  = '0;
    sticky_clr = 1'b0;
  endtask

  task automatic deliver(input logic [31:0] res, input logic [4:0] flg);
    alu_valid  = 1'b1;
    alu_result = res;
    alu_flags  = flg;
    $display("tx result=%08h flags=%05b in_flight=%0d count=%0d", res, flg, in_flight, count);
    tick();
    alu_valid  = 1'b0;
    alu_result = '0;
    alu_flags  = '0;
  endtask

  always @(negedge clk) begin
    if (!rst) check("invariant", 64'(int'(in_flight) + int'(count) <= DEPTH), 64'd1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_in_flight", in_flight, 0);
    check("rst_sticky", sticky_flags, 0);
    check("rst_err", overflow_err, 0);
    check("rst_out_result", out_result, 0);

    // Single operation with a 5-cycle ALU latency
    issue_req = 1'b1;
    #1 check("t1_grant", issue_grant, 1);
    tick();
    issue_req = 1'b0;
    check("t1_in_flight_1", in_flight, 1);
    repeat (4) tick();
    deliver(32'h4040_0000, 5'b00000);
    check("t1_out_valid", out_valid, 1);
    check("t1_out_result", out_result, 32'h4040_0000);
    check("t1_in_flight_0", in_flight, 0);
    check("t1_count_1", count, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_count_0", count, 0);
    check("t1_out_valid_0", out_valid, 0);

    // Credit exhaustion with the consumer stalled
    grants = 0;
    issue_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1 if (issue_grant) grants++;
      tick();
    end
    check("t2_grants", 64'(grants), 4);
    check("t2_in_flight_4", in_flight, 4);
    #1 check("t2_grant_blocked", issue_grant, 0);
    issue_req = 1'b0;
    for (int i = 0; i < 4; i++)
      deliver(32'h3F80_0000 + 32'(i), (i == 1) ? 5'b00100 : 5'b00000);
    check("t2_count_4", count, 4);
    check("t2_in_flight_0", in_flight, 0);
    check("t2_head", out_result, 32'h3F80_0000);
    check("t2_sticky", sticky_flags, 5'b00100);
    check("t2_err", overflow_err, 0);
    issue_req = 1'b1;
    #1 check("t2_grant_full", issue_grant, 0);
    issue_req = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t2_count_3", count, 3);
    check("t2_head2", out_result, 32'h3F80_0001);
    check("t2_head2_flags", out_flags, 5'b00100);
    issue_req = 1'b1;
    #1 check("t2_grant_back", issue_grant, 1);
    issue_req = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    check("t2_drained", count, 0);

    // Clear without capture, then same-cycle special-case result
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    check("t3_sticky_clr", sticky_flags, 0);
    issue_req  = 1'b1;
    alu_valid  = 1'b1;
    alu_result = 32'h7FC0_0000;
    alu_flags  = 5'b01000;
    #1 check("t3_grant", issue_grant, 1);
    tick();
    idle_inputs();
    check("t3_in_flight", in_flight, 0);
    check("t3_count", count, 1);
    check("t3_out_result", out_result, 32'h7FC0_0000);
    check("t3_out_flags", out_flags, 5'b01000);
    check("t3_sticky", sticky_flags, 5'b01000);
    check("t3_err", overflow_err, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Sticky clear colliding with captures
    sticky_clr = 1'b1;
    issue_req  = 1'b1;
    alu_valid  = 1'b1;
    alu_result = 32'h3F00_0000;
    alu_flags  = 5'b00100;
    tick();
    idle_inputs();
    check("t4_sticky_a", sticky_flags, 5'b00100);
    issue_req = 1'b1;
    tick();
    issue_req = 1'b0;
    check("t4_in_flight", in_flight, 1);
    sticky_clr = 1'b1;
    deliver(32'h7F80_0000, 5'b00001);
    sticky_clr = 1'b0;
    check("t4_sticky_b", sticky_flags, 5'b00001);
    check("t4_count", count, 2);
    check("t4_in_flight_0", in_flight, 0);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    check("t4_sticky_clr", sticky_flags, 0);
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    check("t4_drained", count, 0);

    // Unexpected result sets the sticky error and is dropped
    deliver(32'hDEAD_BEEF, 5'b11111);
    check("t5_err", overflow_err, 1);
    check("t5_count", count, 0);
    check("t5_in_flight", in_flight, 0);
    check("t5_sticky", sticky_flags, 0);
    issue_req  = 1'b1;
    alu_valid  = 1'b1;
    alu_result = 32'h4000_0000;
    tick();
    idle_inputs();
    check("t5_clean_count", count, 1);
    check("t5_err_hold", overflow_err, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t5_err_hold2", overflow_err, 1);
    check("t5_count_0", count, 0);

    // Asynchronous reset mid-stream
    issue_req = 1'b1;
    repeat (4) tick();
    issue_req = 1'b0;
    deliver(32'h4100_0000, 5'b00010);
    deliver(32'h4110_0000, 5'b00000);
    deliver(32'h4120_0000, 5'b00000);
    check("t6_count_3", count, 3);
    check("t6_in_flight_1", in_flight, 1);
    check("t6_sticky", sticky_flags, 5'b00010);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_count", count, 0);
    check("t6_rst_in_flight", in_flight, 0);
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_out_result", out_result, 0);
    check("t6_rst_out_flags", out_flags, 0);
    check("t6_rst_sticky", sticky_flags, 0);
    check("t6_rst_err", overflow_err, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    deliver(32'h4130_0000, 5'b00000);
    check("t6_late_err", overflow_err, 1);
    check("t6_late_count", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fp_result_collector
